// File: rtl/ddram_pkg.sv
// Shared DDR Avalon-MM widths and bridge FSM states, also used by the arbiter.
// No logic; constants and types only.
// Not applicable: no handshake in a package.
package ddram_pkg;

  localparam int DDR_AW  = 29;
  localparam int DDR_DW  = 64;
  localparam int DDR_BCW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_CMD  = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR_CMD  = 2'd3
  } ddr_state_e;

endpackage

// File: rtl/ddram_avl_bridge.sv
// Bridges the arbiter's level-request read/write port onto a DDR Avalon-MM master.
// Latency: ack 1 cycle after capture; read beat 1 cycle after ddr_dout_ready.
// Backpressure: commands held on ddr_rd/ddr_we while ddr_busy; wr_busy flags non-idle.
module ddram_avl_bridge
  import ddram_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic [DDR_AW-1:0]    rd_addr,
  input  logic [DDR_BCW-1:0]   rd_burstcnt,
  input  logic                 rd_req,
  output logic                 rd_ack,
  output logic [DDR_DW-1:0]    rd_data,
  output logic                 rd_data_valid,

  input  logic [DDR_AW-1:0]    wr_addr,
  input  logic [DDR_BCW-1:0]   wr_burstcnt,
  input  logic [DDR_DW-1:0]    wr_data,
  input  logic [DDR_DW/8-1:0]  wr_be,
  input  logic                 wr_req,
  output logic                 wr_ack,
  output logic                 wr_busy,

  output logic [DDR_AW-1:0]    ddr_addr,
  output logic [DDR_BCW-1:0]   ddr_burstcnt,
  output logic                 ddr_rd,
  output logic                 ddr_we,
  output logic [DDR_DW-1:0]    ddr_din,
  output logic [DDR_DW/8-1:0]  ddr_be,
  input  logic                 ddr_busy,
  input  logic [DDR_DW-1:0]    ddr_dout,
  input  logic                 ddr_dout_ready
);

  // Writes are always single-beat, so the requested write burst length is unused.
  logic unused_wr_burstcnt;
  assign unused_wr_burstcnt = ^wr_burstcnt;

  ddr_state_e             state_q,    state_d;
  logic [DDR_AW-1:0]      addr_q,     addr_d;
  logic [DDR_BCW-1:0]     bcnt_q,     bcnt_d;
  logic [DDR_DW-1:0]      din_q,      din_d;
  logic [DDR_DW/8-1:0]    be_q,       be_d;
  logic [DDR_BCW-1:0]     cnt_q,      cnt_d;
  logic                   rd_ack_q,   rd_ack_d;
  logic                   wr_ack_q,   wr_ack_d;
  logic [DDR_DW-1:0]      rd_data_q,  rd_data_d;
  logic                   rd_vld_q,   rd_vld_d;
  logic                   ddr_rd_q,   ddr_rd_d;
  logic                   ddr_we_q,   ddr_we_d;

  // Next-state and registered-output computation for the request FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    din_d     = din_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    ddr_rd_d  = 1'b0;
    ddr_we_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Read has priority when both requests are raised together.
        if (rd_req) begin
          addr_d   = rd_addr;
          bcnt_d   = (rd_burstcnt == '0) ? DDR_BCW'(1) : rd_burstcnt;
          rd_ack_d = 1'b1;
          ddr_rd_d = 1'b1;
          state_d  = ST_RD_CMD;
        end else if (wr_req) begin
          addr_d   = wr_addr;
          din_d    = wr_data;
          be_d     = wr_be;
          bcnt_d   = DDR_BCW'(1);
          wr_ack_d = 1'b1;
          ddr_we_d = 1'b1;
          state_d  = ST_WR_CMD;
        end
      end

      ST_RD_CMD: begin
        if (ddr_busy) begin
          ddr_rd_d = 1'b1;
        end else begin
          cnt_d   = bcnt_q;
          state_d = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (ddr_dout_ready) begin
          rd_data_d = ddr_dout;
          rd_vld_d  = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DDR_BCW'(1);
          end
          // Last beat (or a counter that somehow reached zero) ends the burst.
          if (cnt_q <= DDR_BCW'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_WR_CMD: begin
        if (ddr_busy) begin
          ddr_we_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any command or burst in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      bcnt_q    <= '0;
      din_q     <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      ddr_rd_q  <= 1'b0;
      ddr_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      din_q     <= din_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      ddr_rd_q  <= ddr_rd_d;
      ddr_we_q  <= ddr_we_d;
    end
  end

  assign rd_ack        = rd_ack_q;
  assign wr_ack        = wr_ack_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_vld_q;
  assign ddr_addr      = addr_q;
  assign ddr_burstcnt  = bcnt_q;
  assign ddr_rd        = ddr_rd_q;
  assign ddr_we        = ddr_we_q;
  assign ddr_din       = din_q;
  assign ddr_be        = be_q;

  // Upstream sees the bridge busy whenever it is mid-transaction or DDR stalls.
  assign wr_busy = (state_q != ST_IDLE) || ddr_busy;

endmodule

// File: doc/ddram_avl_bridge.md
DDRAM_AVL_BRIDGE -- requirements
Module: ddram_avl_bridge

Interface
REQ-001 SHALL have ports:
- clk  in  1  sole clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
REQ-002 SHALL have these upstream ports, facing the arbiter's dc_* side:
- rd_addr  in  29  read word address.
- rd_burstcnt  in  8  read beats.
- rd_req  in  1  level read request.
- rd_ack  out  1  one-cycle accept pulse.
- rd_data  out  64  read beat.
- rd_data_valid  out  1  beat strobe.
- wr_addr  in  29  write word address.
- wr_burstcnt  in  8  ignored.
- wr_data  in  64  write beat.
- wr_be  in  8  byte enables.
- wr_req  in  1  level write request.
- wr_ack  out  1  one-cycle accept pulse.
- wr_busy  out  1  bridge not idle.
REQ-003 SHALL have these downstream Avalon-MM ports:
- ddr_addr  out  29.
- ddr_burstcnt  out  8.
- ddr_rd  out  1.
- ddr_we  out  1.
- ddr_din  out  64.
- ddr_be  out  8.
- ddr_busy  in  1  waitrequest.
- ddr_dout  in  64.
- ddr_dout_ready  in  1  read beat valid.

Function
REQ-004 SHALL implement FSM states IDLE, RD_CMD, RD_DATA and WR_CMD.
REQ-005 IDLE, rd_req=1: SHALL capture rd_addr and rd_burstcnt (0 captured as 1), then enter RD_CMD.
- Read SHALL win when rd_req and wr_req are both high.
REQ-006 IDLE, wr_req=1 and rd_req=0: SHALL capture wr_addr, wr_data and wr_be, then enter WR_CMD.
REQ-007 rd_ack and wr_ack SHALL be registered and high for exactly the one cycle after the capture edge, never in any other cycle.
REQ-008 RD_CMD: ddr_rd=1 with captured addr/burstcnt.
- Held until an edge with ddr_busy=0, then enter RD_DATA with beat counter = captured burstcnt.
REQ-009 RD_DATA: each cycle with ddr_dout_ready=1 SHALL do the following on the next cycle:
- register ddr_dout into rd_data;
- pulse rd_data_valid;
- decrement the counter.
- The beat taking the counter 1->0 SHALL return the FSM to IDLE on the same edge.
REQ-010 Read-data latency SHALL be exactly 1 cycle from ddr_dout_ready to rd_data_valid.
- rd_data SHALL hold its last value when rd_data_valid=0.
REQ-011 ddr_dout_ready outside RD_DATA SHALL be ignored: no rd_data_valid, no state change.
REQ-012 WR_CMD: ddr_we=1, ddr_burstcnt=1, ddr_din/ddr_be/ddr_addr from captured values.
- Held until an edge with ddr_busy=0, then return to IDLE.
REQ-013 ddr_rd and ddr_we SHALL never be high together; both SHALL be 0 in IDLE and RD_DATA.
REQ-014 Writes SHALL be single-beat; wr_burstcnt SHALL have no effect.
REQ-015 wr_busy SHALL be 1 when state != IDLE or ddr_busy=1, else 0 (combinational).
REQ-016 IDLE SHALL not accept a new request in the cycle it is entered from RD_DATA/WR_CMD unless req is still high.
- The requestor drops req on the edge it samples ack, so no double capture occurs.
REQ-017 Beat counter SHALL be 8 bits and SHALL not underflow; a burst of 255 SHALL be supported.

Reset
REQ-018 reset_n=0 at an edge SHALL force state IDLE and clear the counter, even mid-burst or mid-command.
REQ-019 Outputs SHALL be 0 during and after reset:
- rd_ack, wr_ack, rd_data_valid, ddr_rd, ddr_we;
- rd_data, ddr_addr, ddr_burstcnt, ddr_din, ddr_be.
REQ-020 Beats still arriving after reset SHALL be dropped.

Structure
REQ-021 State enum, DDR_AW=29, DDR_DW=64 and DDR_BCW=8 SHALL live in a shared package, ddram_pkg, reused by the arbiter.
REQ-022 Single flat module, no sub-modules.

Verification
REQ-023 Read, rd_req=1, addr=0x0001000, burst=4, ddr_busy=0:
- rd_ack one cycle later.
- ddr_rd=1 for 1 cycle with burstcnt=4.
- 4 dout_ready beats D0..D3 -> 4 rd_data_valid pulses, each 1 cycle after its dout_ready.
- FSM back in IDLE.
REQ-024 Write, wr_req=1, data=0xDEADBEEF_CAFEF00D, be=0x0F, ddr_busy=1 for 3 cycles:
- ddr_we held 4 cycles, ddr_burstcnt=1.
- wr_busy=1 throughout.
- wr_ack exactly once.
REQ-025 rd_req and wr_req asserted in the same cycle:
- read served first: rd_ack, 2 beats.
- then wr_ack once wr_req is still high in IDLE.
REQ-026 rd_burstcnt=0 -> ddr_burstcnt=1; one beat returns to IDLE.
- Spurious ddr_dout_ready in IDLE -> no rd_data_valid.
REQ-027 reset_n=0 after beat 2 of a burst of 8:
- all outputs 0, state IDLE.
- remaining 6 beats produce no rd_data_valid.
- a new read then completes normally.
